fsk_carrier_div: RTL and testbench
==================================

Name: fsk_carrier_div

Overview:
- Parametrised, runtime-selectable clock-enable/carrier divider for the 2FSK modulator path.
- Generates a 50%-duty square carrier `clk_out` from `clk_in`.
- Divide ratio is chosen by a one-hot-style switch bus; the highest set bit wins.
- Ratio changes are applied only on a carrier edge, so no runt pulses occur. Edge ticks are provided for downstream logic.

Parameters:
- SEL_N, 4, number of selectable ratios (width of `sel`).
- BASE_DIV, 32, full-period divide for `sel` index 0; index k divides by BASE_DIV >> k. Must be even and BASE_DIV >> (SEL_N-1) >= 2.
- CNT_W, 14, half-period counter width; must hold BASE_DIV/2 - 1.

Ports:
- clk_in  input  1  system clock.
- rst_n  input  1  reset. One clock; reset is asynchronous and active-low.
- en  input  1  run enable; 0 freezes counter and `clk_out` level.
- sel  input  SEL_N  ratio select; highest set bit index k selects divide BASE_DIV >> k; all-zero = idle.
- clk_out  output  1  divided carrier, 50% duty.
- rise_tick  output  1  one-cycle pulse in the cycle `clk_out` goes 0->1.
- fall_tick  output  1  one-cycle pulse in the cycle `clk_out` goes 1->0.
- active_idx  output  $clog2(SEL_N)  index of the ratio currently in effect.
- active_vld  output  1  1 when a ratio is in effect (not idle).

Behaviour:
- Reset (async assert, sync-to-clock release is upstream's job): `cnt`=0, `clk_out`=0, ticks=0, `active_idx`=0, `active_vld`=0, `half`=0.
- Decode every cycle: `req_idx` = highest set bit of `sel`; `req_vld` = |`sel`; `req_half` = (BASE_DIV >> `req_idx`)/2 - 1.
- States:
  - IDLE (`active_vld`=0): `clk_out` held at 0, `cnt` held at 0. If `en` & `req_vld`: load `half`=`req_half`, `active_idx`=`req_idx`, `active_vld`=1, `cnt`=0, go RUN. The first toggle follows (`half`+1) cycles later.
  - RUN, `en`=1: if `cnt`==`half`, then toggle `clk_out`, pulse the matching tick, `cnt`=0, and resample the request:
    - `req_vld`=0: return to IDLE only when toggling to 0; otherwise keep the old ratio until the next falling toggle.
    - `req_idx` differs: adopt new `half`/`active_idx` at this toggle.
  - RUN, `en`=1, `cnt` != `half`: `cnt`+1.
  - RUN, `en`=0: all state frozen, ticks 0.
- `sel` changes mid half-period have no effect until the next toggle. Simultaneous toggle and `sel` change: the new value is sampled at that toggle.
- Steady state: period = BASE_DIV >> `active_idx` cycles exactly; high time = low time.
- Ticks are registered, coincident with the `clk_out` edge, never both high.
- `rst_n` low mid-operation: immediate return to reset values regardless of state.

Optional Feature:
- Macro `FSK_CARRIER_DIV_SYNC_EN`.
- Defined: `sel` passes through a 2-flop synchroniser (reset 0) before decode. This adds 2 cycles of `sel` latency and makes the bus safe for raw board switches.
- Undefined: `sel` is decoded directly, with zero added latency.

Test Plan:
- Reset, then `en`=1, `sel`=4'b0001 → `clk_out` period 32 cycles, 16 high/16 low. The first rise occurs 16 cycles after the entry cycle; `rise_tick` and `fall_tick` are each 1 cycle wide; `active_idx`=0.
- `sel`=4'b1011 → highest bit wins: period 4 (2 high/2 low); `active_idx`=3.
- Running at /32, switch `sel` to 4'b0100 mid half-period (`cnt`=5) → the current half-period still lasts 16 cycles, then period 8 from that toggle; no high or low pulse shorter than 4 cycles.
- Running at /8 with `clk_out`=1, set `sel`=0 → remaining high half completes (4 cycles), falls, IDLE; `active_vld`=0, `clk_out` stays 0.
- `en`=0 for 7 cycles mid-run, then `en`=1 → `clk_out` and `cnt` frozen, no ticks; the half-period resumes with its remaining count.
- Assert `rst_n`=0 asynchronously mid-high at /16 → `clk_out`=0, `active_vld`=0 immediately. With the macro defined, a `sel` change takes effect 2 cycles later than without it.

Source files
------------

// File: rtl/fsk_carrier_div.sv
// Runtime-selectable 50%-duty carrier divider for the 2FSK modulator path.
// Define FSK_CARRIER_DIV_SYNC_EN to put a 2-flop synchroniser on sel.
module fsk_carrier_div #(
  parameter int SEL_N    = 4,
  parameter int BASE_DIV = 32,
  parameter int CNT_W    = 14
) (
  input  logic                       clk_in,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic [SEL_N-1:0]           sel,
  output logic                       clk_out,
  output logic                       rise_tick,
  output logic                       fall_tick,
  output logic [$clog2(SEL_N)-1:0]   active_idx,
  output logic                       active_vld
);

  localparam int IDX_W = $clog2(SEL_N);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  logic [SEL_N-1:0] w_sel;
  logic [IDX_W-1:0] w_req_idx;
  logic             w_req_vld;
  logic [CNT_W-1:0] w_req_half;
  logic [CNT_W-1:0] w_half_tab [SEL_N];

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_half;
  logic             r_clk_out;
  logic             r_rise;
  logic             r_fall;
  logic [IDX_W-1:0] r_active_idx;
  logic             r_active_vld;

`ifdef FSK_CARRIER_DIV_SYNC_EN
  logic [SEL_N-1:0] r_sel_s1;
  logic [SEL_N-1:0] r_sel_s2;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_sel_s1 <= '0;
      r_sel_s2 <= '0;
    end else begin
      r_sel_s1 <= sel;
      r_sel_s2 <= r_sel_s1;
    end
  end

  assign w_sel = r_sel_s2;
`else
  assign w_sel = sel;
`endif

  // Half-period terminal counts, one per selectable ratio.
  genvar gi;
  generate
    for (gi = 0; gi < SEL_N; gi++) begin : g_half
      assign w_half_tab[gi] = CNT_W'((BASE_DIV >> gi) / 2 - 1);
    end
  endgenerate

  // Highest set bit wins: later iterations override earlier ones.
  always_comb begin
    w_req_idx = '0;
    for (int i = 0; i < SEL_N; i++) begin
      if (w_sel[i]) w_req_idx = IDX_W'(i);
    end
  end

  assign w_req_vld  = |w_sel;
  assign w_req_half = w_half_tab[w_req_idx];

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_half       <= '0;
      r_clk_out    <= 1'b0;
      r_rise       <= 1'b0;
      r_fall       <= 1'b0;
      r_active_idx <= '0;
      r_active_vld <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_clk_out <= 1'b0;
          r_cnt     <= '0;
          if (en && w_req_vld) begin
            r_half       <= w_req_half;
            r_active_idx <= w_req_idx;
            r_active_vld <= 1'b1;
            r_state      <= S_RUN;
          end
        end
        S_RUN: begin
          if (en) begin
            if (r_cnt == r_half) begin
              r_clk_out <= ~r_clk_out;
              r_rise    <= ~r_clk_out;
              r_fall    <= r_clk_out;
              r_cnt     <= '0;
              // Ratio changes and stop requests only land on a toggle;
              // a stop while low->high keeps running until the next fall.
              if (!w_req_vld) begin
                if (r_clk_out) begin
                  r_state      <= S_IDLE;
                  r_active_vld <= 1'b0;
                end
              end else if (w_req_idx != r_active_idx) begin
                r_half       <= w_req_half;
                r_active_idx <= w_req_idx;
              end
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign clk_out    = r_clk_out;
  assign rise_tick  = r_rise;
  assign fall_tick  = r_fall;
  assign active_idx = r_active_idx;
  assign active_vld = r_active_vld;

endmodule

// File: tb/tb_fsk_carrier_div.sv
// Directed self-checking bench for fsk_carrier_div (default parameters).
module tb_fsk_carrier_div;

`ifdef FSK_CARRIER_DIV_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clk_in;
  logic       rst_n;
  logic       en;
  logic [3:0] sel;
  logic       clk_out;
  logic       rise_tick;
  logic       fall_tick;
  logic [1:0] active_idx;
  logic       active_vld;

  int checks = 0;
  int errors = 0;
  bit both_seen = 0;

  fsk_carrier_div #(.SEL_N(4), .BASE_DIV(32), .CNT_W(14)) dut (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .en         (en),
    .sel        (sel),
    .clk_out    (clk_out),
    .rise_tick  (rise_tick),
    .fall_tick  (fall_tick),
    .active_idx (active_idx),
    .active_vld (active_vld)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
    if (rise_tick && fall_tick) both_seen = 1;
  endtask

  // Returns edges elapsed until the requested tick is seen, or -1 on timeout.
  task automatic wait_tick(input bit want_rise, input int max, output int n);
    bit seen;
    seen = 0;
    n = 0;
    while (!seen && n < max) begin
      tick();
      n++;
      if (want_rise ? rise_tick : fall_tick) seen = 1;
    end
    if (!seen) n = -1;
  endtask

  task automatic start_run(input logic [3:0] selv, input int div);
    int n;
    rst_n = 1'b0;
    en    = 1'b0;
    sel   = 4'b0000;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    en  = 1'b1;
    sel = selv;
    wait_tick(1'b1, 200, n);
    checks++;
    if (n !== div / 2 + 1 + LAT) begin
      errors++;
      $display("FAIL first_rise div=%0d edges got %0d want %0d", div, n, div / 2 + 1 + LAT);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en    = 1'b0;
    sel   = 4'b0000;
    tick();
    checks++;
    if ({clk_out, rise_tick, fall_tick, active_vld, active_idx} !== 6'b0) begin
      errors++;
      $display("FAIL reset_state got %b want 000000",
               {clk_out, rise_tick, fall_tick, active_vld, active_idx});
    end
    $display("reset: outputs checked");
  endtask

  task automatic test_div32();
    int n;
    start_run(4'b0001, 32);
    tick();
    checks++;
    if (rise_tick !== 1'b0 || clk_out !== 1'b1) begin
      errors++;
      $display("FAIL rise_width rise_tick=%b clk_out=%b want 0 1", rise_tick, clk_out);
    end
    wait_tick(1'b0, 100, n);
    checks++;
    if (n !== 15) begin
      errors++;
      $display("FAIL high_time32 edges got %0d want 15", n);
    end
    tick();
    checks++;
    if (fall_tick !== 1'b0 || clk_out !== 1'b0) begin
      errors++;
      $display("FAIL fall_width fall_tick=%b clk_out=%b want 0 0", fall_tick, clk_out);
    end
    wait_tick(1'b1, 100, n);
    checks++;
    if (n !== 15) begin
      errors++;
      $display("FAIL low_time32 edges got %0d want 15", n);
    end
    checks++;
    if (active_idx !== 2'd0 || active_vld !== 1'b1) begin
      errors++;
      $display("FAIL idx32 idx=%0d vld=%b want 0 1", active_idx, active_vld);
    end
    $display("div32: first rise, 16 high / 16 low");
  endtask

  task automatic test_highest_bit();
    int n;
    start_run(4'b1011, 4);
    wait_tick(1'b0, 50, n);
    checks++;
    if (n !== 2) begin
      errors++;
      $display("FAIL high_time4 edges got %0d want 2", n);
    end
    wait_tick(1'b1, 50, n);
    checks++;
    if (n !== 2) begin
      errors++;
      $display("FAIL low_time4 edges got %0d want 2", n);
    end
    checks++;
    if (active_idx !== 2'd3) begin
      errors++;
      $display("FAIL idx_highest got %0d want 3", active_idx);
    end
    $display("highest_bit: sel=1011 divides by 4");
  endtask

  task automatic test_midchange();
    int n;
    start_run(4'b0001, 32);
    repeat (5) tick();
    sel = 4'b0100;
    wait_tick(1'b0, 100, n);
    checks++;
    if (n !== 11) begin
      errors++;
      $display("FAIL mid_half_keep edges got %0d want 11", n);
    end
    wait_tick(1'b1, 100, n);
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL new_low8 edges got %0d want 4", n);
    end
    wait_tick(1'b0, 100, n);
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL new_high8 edges got %0d want 4", n);
    end
    checks++;
    if (active_idx !== 2'd2) begin
      errors++;
      $display("FAIL idx_mid got %0d want 2", active_idx);
    end
    $display("midchange: /32 half completes, then /8");
  endtask

  task automatic test_idle_return();
    int n;
    start_run(4'b0100, 8);
    sel = 4'b0000;
    wait_tick(1'b0, 50, n);
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL stop_high_done edges got %0d want 4", n);
    end
    checks++;
    if (active_vld !== 1'b0 || clk_out !== 1'b0) begin
      errors++;
      $display("FAIL stop_idle vld=%b clk_out=%b want 0 0", active_vld, clk_out);
    end
    wait_tick(1'b1, 12, n);
    checks++;
    if (n !== -1 || clk_out !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold rise_edge=%0d clk_out=%b want -1 0", n, clk_out);
    end
    $display("idle_return: high half finished, carrier parked low");
  endtask

  task automatic test_en_freeze();
    int n;
    bit frozen_ok;
    start_run(4'b0010, 16);
    repeat (3) tick();
    en = 1'b0;
    frozen_ok = 1;
    repeat (7) begin
      tick();
      if (clk_out !== 1'b1 || rise_tick !== 1'b0 || fall_tick !== 1'b0) frozen_ok = 0;
    end
    checks++;
    if (frozen_ok !== 1'b1) begin
      errors++;
      $display("FAIL freeze_hold got %b want 1", frozen_ok);
    end
    en = 1'b1;
    wait_tick(1'b0, 50, n);
    checks++;
    if (n !== 5) begin
      errors++;
      $display("FAIL freeze_resume edges got %0d want 5", n);
    end
    $display("en_freeze: 7 frozen cycles, remaining count resumed");
  endtask

  task automatic test_async_reset();
    int n;
    start_run(4'b0010, 16);
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (clk_out !== 1'b0 || active_vld !== 1'b0) begin
      errors++;
      $display("FAIL async_reset clk_out=%b vld=%b want 0 0", clk_out, active_vld);
    end
    en  = 1'b1;
    sel = 4'b0000;
    tick();
    rst_n = 1'b1;
    tick();
    sel = 4'b0001;
    n = -1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (active_vld) begin
        n = i;
        break;
      end
    end
    checks++;
    if (n !== 1 + LAT) begin
      errors++;
      $display("FAIL sel_latency edges got %0d want %0d", n, 1 + LAT);
    end
    $display("async_reset: immediate clear, sel latency checked");
  endtask

  task automatic test_tick_exclusive();
    checks++;
    if (both_seen !== 1'b0) begin
      errors++;
      $display("FAIL tick_exclusive both_seen got %b want 0", both_seen);
    end
    $display("tick_exclusive: rise/fall never together");
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    sel   = 4'b0000;
    test_reset();
    test_div32();
    test_highest_bit();
    test_midchange();
    test_idle_return();
    test_en_freeze();
    test_async_reset();
    test_tick_exclusive();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
